cache_data_array: RTL and testbench

Multi-way, parametrised data array for the data cache: one line per (way, set), word-granular masked writes, and a registered read port that returns every way of the addressed set in parallel for tag-hit selection. The cache controller drives it. It replaces the single-way, single-cycle-cleared store. Contents are now cleared by a sequential sweep after reset, one set per cycle, so the array can map to block RAM.

---
 rtl/cache_pkg.sv | 14 +
 rtl/cache_data_bank.sv | 42 ++++
 rtl/cache_data_array.sv | 148 ++++++++++++++
 tb/tb_cache_data_array.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared constants and FSM state type for the data cache array.
package cache_pkg;

  localparam int DEF_WAYS   = 2;
  localparam int DEF_SETS   = 256;
  localparam int DEF_LINE_W = 128;
  localparam int WORD_W     = 32;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/cache_data_bank.sv
// One cache way: SETS x LINE_W storage, word-masked synchronous write,
// registered read-first output that holds when no read is issued.
module cache_data_bank
  import cache_pkg::*;
#(
  parameter int SETS   = DEF_SETS,
  parameter int LINE_W = DEF_LINE_W,
  localparam int IDX_W = $clog2(SETS),
  localparam int WORDS = LINE_W / WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [WORDS-1:0]  wmask,
  input  logic [LINE_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [SETS];

  // Storage write: each 32-bit word has its own enable
  always_ff @(posedge clk) begin
    for (int k = 0; k < WORDS; k++) begin
      if (we && wmask[k]) begin
        mem[waddr][k*WORD_W +: WORD_W] <= wdata[k*WORD_W +: WORD_W];
      end
    end
  end

  // Output register sees the pre-write contents on a same-edge collision
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= {LINE_W{1'b0}};
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/cache_data_array.sv
// Multi-way cache data array with post-reset clear sweep and registered reads.
// Optional macro CACHE_DATA_BYPASS_EN forwards same-edge writes into read data.
module cache_data_array
  import cache_pkg::*;
#(
  parameter int WAYS   = DEF_WAYS,
  parameter int SETS   = DEF_SETS,
  parameter int LINE_W = DEF_LINE_W,
  localparam int IDX_W = $clog2(SETS),
  localparam int WORDS = LINE_W / WORD_W,
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   ready,
  input  logic                   rd_en,
  input  logic [IDX_W-1:0]       rindex,
  output logic [WAYS*LINE_W-1:0] rdata,
  output logic                   rvalid,
  input  logic                   we,
  input  logic [WAY_W-1:0]       wway,
  input  logic [IDX_W-1:0]       windex,
  input  logic [WORDS-1:0]       wmask,
  input  logic [LINE_W-1:0]      wdata
);

  state_t                   state;
  state_t                   next_state;
  logic [IDX_W-1:0]         clr_idx;
  logic                     clr_en;
  logic                     acc_rd;
  logic                     acc_we;
  logic [IDX_W-1:0]         bank_waddr;
  logic [WORDS-1:0]         bank_wmask;
  logic [LINE_W-1:0]        bank_wdata;
  logic [WAYS*LINE_W-1:0]   bank_rdata;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
    end else begin
      state <= next_state;
    end
  end

  // Next state: the sweep ends after the last set has been cleared
  always_comb begin
    next_state = state;
    case (state)
      CLEAR:   next_state = (clr_idx == IDX_W'(SETS - 1)) ? READY : CLEAR;
      READY:   next_state = READY;
      default: next_state = CLEAR;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready  = 1'b0;
    clr_en = 1'b0;
    case (state)
      CLEAR:   clr_en = ~rst;
      READY:   ready  = 1'b1;
      default: clr_en = 1'b0;
    endcase
  end

  // Clear sweep pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_idx <= {IDX_W{1'b0}};
    end else if (clr_en) begin
      clr_idx <= clr_idx + IDX_W'(1);
    end
  end

  assign acc_rd = ready & rd_en & ~rst;
  assign acc_we = ready & we & ~rst;

  assign bank_waddr = clr_en ? clr_idx : windex;
  assign bank_wmask = clr_en ? {WORDS{1'b1}} : wmask;
  assign bank_wdata = clr_en ? {LINE_W{1'b0}} : wdata;

  // Read-valid pulse follows each accepted read by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
    end else begin
      rvalid <= acc_rd;
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic bank_we;
    // Out-of-range way numbers match no bank, so such writes vanish
    assign bank_we = clr_en | (acc_we & (wway == WAY_W'(w)));

    cache_data_bank #(
      .SETS   (SETS),
      .LINE_W (LINE_W)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (bank_we),
      .waddr (bank_waddr),
      .wmask (bank_wmask),
      .wdata (bank_wdata),
      .re    (acc_rd),
      .raddr (rindex),
      .rdata (bank_rdata[w*LINE_W +: LINE_W])
    );
  end

`ifdef CACHE_DATA_BYPASS_EN
  logic [WAYS-1:0]   byp_way;
  logic [WORDS-1:0]  byp_mask;
  logic [LINE_W-1:0] byp_data;

  // Capture the colliding write alongside the read so the merge uses only registers
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_way  <= {WAYS{1'b0}};
      byp_mask <= {WORDS{1'b0}};
      byp_data <= {LINE_W{1'b0}};
    end else if (acc_rd) begin
      byp_mask <= wmask;
      byp_data <= wdata;
      for (int w = 0; w < WAYS; w++) begin
        byp_way[w] <= acc_we && (windex == rindex) && (wway == WAY_W'(w));
      end
    end
  end

  // Overlay forwarded words onto the stored line of the written way
  always_comb begin
    rdata = bank_rdata;
    for (int w = 0; w < WAYS; w++) begin
      for (int k = 0; k < WORDS; k++) begin
        rdata[w*LINE_W + k*WORD_W +: WORD_W] = (byp_way[w] && byp_mask[k]) ?
            byp_data[k*WORD_W +: WORD_W] : bank_rdata[w*LINE_W + k*WORD_W +: WORD_W];
      end
    end
  end
`else
  assign rdata = bank_rdata;
`endif

endmodule

// File: tb/tb_cache_data_array.sv
// Randomized self-checking bench for cache_data_array against a line-level
// memory model; honours CACHE_DATA_BYPASS_EN the same way as the design.
module tb_cache_data_array;

  localparam int WAYS   = 3;
  localparam int SETS   = 256;
  localparam int LINE_W = 128;
  localparam int WORDS  = 4;
  localparam int RW     = WAYS * LINE_W;

  logic            clk = 1'b0;
  logic            rst;
  logic            ready;
  logic            rd_en;
  logic [7:0]      rindex;
  logic [RW-1:0]   rdata;
  logic            rvalid;
  logic            we;
  logic [1:0]      wway;
  logic [7:0]      windex;
  logic [3:0]      wmask;
  logic [127:0]    wdata;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: array of whole lines plus expected outputs
  logic [127:0]  m_mem [WAYS][SETS];
  bit            m_ready;
  int            m_left;
  logic [RW-1:0] e_rdata;
  bit            e_rvalid;

  cache_data_array #(.WAYS(WAYS), .SETS(SETS), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst), .ready(ready), .rd_en(rd_en), .rindex(rindex),
    .rdata(rdata), .rvalid(rvalid), .we(we), .wway(wway), .windex(windex),
    .wmask(wmask), .wdata(wdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [3:0] m,
                                         input logic [127:0] d);
    logic [127:0] r;
    r = old;
    for (int k = 0; k < WORDS; k++) if (m[k]) r[k*32 +: 32] = d[k*32 +: 32];
    return r;
  endfunction

  task automatic drive(input bit r, input bit re, input logic [7:0] ri, input bit w,
                       input logic [1:0] ww, input logic [7:0] wi, input logic [3:0] wm,
                       input logic [127:0] wd);
    rst = r; rd_en = re; rindex = ri; we = w; wway = ww; windex = wi; wmask = wm; wdata = wd;
  endtask

  // Advance the model by one edge from the current inputs, then compare
  task automatic tick();
    logic [127:0] line;
    if (rst) begin
      m_ready  = 1'b0;
      m_left   = SETS;
      e_rdata  = '0;
      e_rvalid = 1'b0;
      for (int w = 0; w < WAYS; w++) for (int s = 0; s < SETS; s++) m_mem[w][s] = '0;
    end else if (!m_ready) begin
      m_left--;
      if (m_left == 0) m_ready = 1'b1;
      e_rvalid = 1'b0;
    end else begin
      if (rd_en) begin
        for (int w = 0; w < WAYS; w++) begin
          line = m_mem[w][rindex];
`ifdef CACHE_DATA_BYPASS_EN
          if (we && int'(wway) == w && windex == rindex) line = merge(line, wmask, wdata);
`endif
          e_rdata[w*LINE_W +: LINE_W] = line;
        end
      end
      e_rvalid = rd_en;
      if (we && int'(wway) < WAYS) m_mem[wway][windex] = merge(m_mem[wway][windex], wmask, wdata);
    end
    @(posedge clk);
    #1;
    check_eq("ready", RW'(ready), RW'(m_ready));
    check_eq("rvalid", RW'(rvalid), RW'(e_rvalid));
    check_eq("rdata", rdata, e_rdata);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'd0, 1'b0, 2'd0, 8'd0, 4'd0, 128'd0);
  endtask

  initial begin
    logic [127:0] exp_line;

    // Reset then hammer requests during the whole sweep
    drive(1'b1, 1'b1, 8'd3, 1'b1, 2'd0, 8'd3, 4'hF, 128'hFFFF);
    tick();
    check_eq("reset_ready", RW'(ready), RW'(1'b0));
    for (int i = 0; i < SETS; i++) begin
      drive(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1, 2'($urandom_range(0, 2)),
            8'($urandom_range(0, 255)), 4'hF, {$urandom, $urandom, $urandom, $urandom});
      tick();
    end
    check_eq("ready_after_sweep", RW'(ready), RW'(1'b1));

    drive(1'b0, 1'b1, 8'd255, 1'b0, 2'd0, 8'd0, 4'd0, 128'd0);
    tick();
    check_eq("set255_zero", rdata, RW'(0));

    // Masked write, then read back
    drive(1'b0, 1'b0, 8'd0, 1'b1, 2'd1, 8'h10, 4'b0101,
          128'hAAAA_AAAA_BBBB_BBBB_CCCC_CCCC_DDDD_DDDD);
    tick();
    drive(1'b0, 1'b1, 8'h10, 1'b0, 2'd0, 8'd0, 4'd0, 128'd0);
    tick();
    check_eq("masked_way1", RW'(rdata[255:128]), RW'(128'h0000_0000_BBBB_BBBB_0000_0000_DDDD_DDDD));
    check_eq("masked_way0", RW'(rdata[127:0]), RW'(0));
    check_eq("masked_rvalid", RW'(rvalid), RW'(1'b1));
    idle();
    tick();
    check_eq("rdata_hold", RW'(rdata[255:128]), RW'(128'h0000_0000_BBBB_BBBB_0000_0000_DDDD_DDDD));

    // Same-edge read and write to set 5
    drive(1'b0, 1'b1, 8'd5, 1'b1, 2'd0, 8'd5, 4'hF, 128'h1234);
    tick();
`ifdef CACHE_DATA_BYPASS_EN
    exp_line = 128'h1234;
`else
    exp_line = 128'h0;
`endif
    check_eq("collision_way0", RW'(rdata[127:0]), RW'(exp_line));

    // Out-of-range way write, combined with a read of the same set
    drive(1'b0, 1'b1, 8'd5, 1'b1, 2'd3, 8'd5, 4'hF, 128'hDEAD_BEEF);
    tick();
    check_eq("after_collision", RW'(rdata[127:0]), RW'(128'h1234));
    check_eq("oob_way_drop", rdata[383:128], 256'h0);
    drive(1'b0, 1'b1, 8'd5, 1'b0, 2'd0, 8'd0, 4'd0, 128'd0);
    tick();
    check_eq("oob_no_change", rdata, RW'(128'h1234));

    // Random traffic over a few sets to provoke collisions
    for (int i = 0; i < 2000; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 8'($urandom_range(0, 7)), 4'($urandom),
            {$urandom, $urandom, $urandom, $urandom});
      tick();
    end

    // Reset mid-sweep: write a set, reset, abort at clear cycle 100, reset again
    drive(1'b0, 1'b0, 8'd0, 1'b1, 2'd2, 8'h40, 4'hF, 128'h5555);
    tick();
    drive(1'b1, 1'b0, 8'd0, 1'b0, 2'd0, 8'd0, 4'd0, 128'd0);
    tick();
    idle();
    for (int i = 0; i < 100; i++) tick();
    drive(1'b1, 1'b0, 8'd0, 1'b0, 2'd0, 8'd0, 4'd0, 128'd0);
    tick();
    for (int i = 0; i < SETS; i++) begin
      drive(1'b0, 1'b1, 8'h40, 1'b1, 2'd2, 8'h40, 4'hF, 128'h7777);
      tick();
    end
    check_eq("ready_after_restart", RW'(ready), RW'(1'b1));
    drive(1'b0, 1'b1, 8'h40, 1'b0, 2'd0, 8'd0, 4'd0, 128'd0);
    tick();
    check_eq("cleared_after_reset", rdata, RW'(0));
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
